pipeline_fetch: RTL and testbench

Instruction-fetch stage and IF/ID pipeline register of the five-stage pipeline. Owns the PC, drives the instruction-cache request, and presents the fetched instruction and next-PC to decode, which latches them. Accepts branch/jump redirects and halt from later stages, and tracks a redirect that lands while an icache miss is still outstanding.

---
 rtl/cpu_types_pkg.sv | 20 ++
 rtl/fetch_perf_counters.sv | 26 ++
 rtl/pipeline_fetch.sv | 129 ++++++++++++
 tb/tb_pipeline_fetch.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU types for the fetch stage: word type, fetch FSM states, word size.
package cpu_types_pkg;

  localparam int unsigned WORD_W     = 32;
  localparam int unsigned WORD_BYTES = 4;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    PEND   = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

  // Force a byte address onto a word boundary.
  function automatic word_t align_word(input word_t addr);
    return {addr[WORD_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_perf_counters.sv
// Fetch performance counters: accepted instructions and RUN cycles without one.
module fetch_perf_counters
  import cpu_types_pkg::*;
(
  input  logic  CLK,
  input  logic  RST,
  input  logic  in_run,
  input  logic  accept,
  output word_t fetch_count,
  output word_t stall_count
);

  // HALTED never asserts in_run/accept, so both counters freeze there.
  always_ff @(posedge CLK) begin
    if (RST) begin
      fetch_count <= '0;
      stall_count <= '0;
    end else begin
      if (accept)
        fetch_count <= fetch_count + word_t'(1);
      if (in_run && !accept)
        stall_count <= stall_count + word_t'(1);
    end
  end

endmodule

// File: rtl/pipeline_fetch.sv
// Instruction-fetch stage with IF/ID register and miss-aware redirect tracking.
// Optional FETCH_PERF_EN adds fetch_count/stall_count performance outputs.
module pipeline_fetch
  import cpu_types_pkg::*;
#(
  parameter word_t PC_INIT = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ihit,
  input  logic [31:0] imemload,
  output logic        imemREN,
  output logic [31:0] imemaddr,
  input  logic        advance,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic [31:0] IF_Instr_OUT,
  output logic [31:0] IF_npc_OUT,
  output logic        IF_valid_OUT,
`ifdef FETCH_PERF_EN
  output logic [31:0] fetch_count,
  output logic [31:0] stall_count,
`endif
  output logic        flush
);

  fetch_state_t state;
  word_t        pc;
  word_t        pending_pc;
  word_t        pc_plus4;

  assign pc_plus4 = pc + word_t'(WORD_BYTES);

  // Address and request follow state; flush reflects a redirect accepted this cycle.
  always_comb begin
    imemaddr = pc;
    imemREN  = (state != HALTED);
    flush    = (state != HALTED) && !halt && advance && redirect;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state        <= RUN;
      pc           <= PC_INIT;
      pending_pc   <= '0;
      IF_Instr_OUT <= '0;
      IF_npc_OUT   <= '0;
      IF_valid_OUT <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (halt) begin
            state        <= HALTED;
            IF_Instr_OUT <= '0;
            IF_npc_OUT   <= '0;
            IF_valid_OUT <= 1'b0;
          end else if (advance) begin
            if (redirect) begin
              IF_Instr_OUT <= '0;
              IF_npc_OUT   <= '0;
              IF_valid_OUT <= 1'b0;
              if (ihit) begin
                pc <= align_word(redirect_pc);
              end else begin
                // Keep the missing address stable; jump once the miss returns.
                pending_pc <= align_word(redirect_pc);
                state      <= PEND;
              end
            end else if (!stall) begin
              if (ihit) begin
                pc           <= pc_plus4;
                IF_Instr_OUT <= imemload;
                IF_npc_OUT   <= pc_plus4;
                IF_valid_OUT <= 1'b1;
              end else begin
                IF_Instr_OUT <= '0;
                IF_npc_OUT   <= '0;
                IF_valid_OUT <= 1'b0;
              end
            end
          end
        end
        PEND: begin
          if (halt) begin
            state <= HALTED;
          end else if (advance) begin
            if (redirect) begin
              if (ihit) begin
                pc    <= align_word(redirect_pc);
                state <= RUN;
              end else begin
                pending_pc <= align_word(redirect_pc);
              end
            end else if (!stall && ihit) begin
              pc    <= pending_pc;
              state <= RUN;
            end
          end
        end
        HALTED: begin
        end
        default: state <= HALTED;
      endcase
    end
  end

`ifdef FETCH_PERF_EN
  logic accept_c;
  word_t fetch_count_w;
  word_t stall_count_w;

  assign accept_c = (state == RUN) && !halt && advance && !redirect && !stall && ihit;

  fetch_perf_counters u_perf (
    .CLK         (CLK),
    .RST         (RST),
    .in_run      (state == RUN),
    .accept      (accept_c),
    .fetch_count (fetch_count_w),
    .stall_count (stall_count_w)
  );

  assign fetch_count = fetch_count_w;
  assign stall_count = stall_count_w;
`endif

endmodule

// File: tb/tb_pipeline_fetch.sv
// Directed self-checking bench for pipeline_fetch (default build).
module tb_pipeline_fetch;

  logic        CLK;
  logic        RST;
  logic        ihit;
  logic [31:0] imemload;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        advance;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        halt;
  logic [31:0] IF_Instr_OUT;
  logic [31:0] IF_npc_OUT;
  logic        IF_valid_OUT;
  logic        flush;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [31:0] I0   = 32'h0010_0093;
  localparam logic [31:0] I4   = 32'h0020_0113;
  localparam logic [31:0] I8   = 32'h0030_0193;
  localparam logic [31:0] IC   = 32'h0040_0213;
  localparam logic [31:0] I200 = 32'h0050_0293;

  pipeline_fetch dut (
    .CLK          (CLK),
    .RST          (RST),
    .ihit         (ihit),
    .imemload     (imemload),
    .imemREN      (imemREN),
    .imemaddr     (imemaddr),
    .advance      (advance),
    .stall        (stall),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .halt         (halt),
    .IF_Instr_OUT (IF_Instr_OUT),
    .IF_npc_OUT   (IF_npc_OUT),
    .IF_valid_OUT (IF_valid_OUT),
    .flush        (flush)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    @(negedge CLK);
  endtask

  initial begin
    RST = 1'b1; ihit = 1'b0; imemload = '0; advance = 1'b1; stall = 1'b0;
    redirect = 1'b0; redirect_pc = '0; halt = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);

    chk("rst_addr",  imemaddr, 32'h0);
    chk("rst_ren",   32'(imemREN), 32'h1);
    chk("rst_instr", IF_Instr_OUT, 32'h0);
    chk("rst_npc",   IF_npc_OUT, 32'h0);
    chk("rst_valid", 32'(IF_valid_OUT), 32'h0);
    chk("rst_flush", 32'(flush), 32'h0);

    // Sequential fetch
    RST = 1'b0; ihit = 1'b1; imemload = I0;
    chk("seq_addr0", imemaddr, 32'h0);
    tick;
    chk("seq_npc4",   IF_npc_OUT, 32'h4);
    chk("seq_instr0", IF_Instr_OUT, I0);
    chk("seq_valid",  32'(IF_valid_OUT), 32'h1);
    chk("seq_addr4",  imemaddr, 32'h4);
    imemload = I4;
    tick;
    chk("seq_npc8",   IF_npc_OUT, 32'h8);
    chk("seq_instr4", IF_Instr_OUT, I4);
    chk("seq_addr8",  imemaddr, 32'h8);

    // Stall at PC=8 for three cycles
    stall = 1'b1; imemload = I8;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("stall_addr",  imemaddr, 32'h8);
      chk("stall_instr", IF_Instr_OUT, I4);
      chk("stall_npc",   IF_npc_OUT, 32'h8);
    end
    stall = 1'b0;
    tick;
    chk("resume_instr8", IF_Instr_OUT, I8);
    chk("resume_npc12",  IF_npc_OUT, 32'hC);
    chk("resume_addrC",  imemaddr, 32'hC);
    imemload = IC;
    tick;
    chk("resume_instrC", IF_Instr_OUT, IC);
    chk("resume_npc16",  IF_npc_OUT, 32'h10);
    chk("resume_addr10", imemaddr, 32'h10);

    // Redirect with hit
    redirect = 1'b1; redirect_pc = 32'h100;
    #1 chk("redir_flush", 32'(flush), 32'h1);
    tick;
    chk("redir_addr",  imemaddr, 32'h100);
    chk("redir_valid", 32'(IF_valid_OUT), 32'h0);
    chk("redir_instr", IF_Instr_OUT, 32'h0);
    redirect = 1'b0;
    #1 chk("redir_flush_off", 32'(flush), 32'h0);

    // Misaligned redirect target is word-aligned
    redirect = 1'b1; redirect_pc = 32'h13;
    tick;
    redirect = 1'b0;
    chk("align_addr", imemaddr, 32'h10);

    // Redirect during a miss at PC=0x10
    ihit = 1'b0; redirect = 1'b1; redirect_pc = 32'h200;
    #1 chk("miss_redir_flush", 32'(flush), 32'h1);
    tick;
    redirect = 1'b0;
    chk("pend_addr",  imemaddr, 32'h10);
    chk("pend_valid", 32'(IF_valid_OUT), 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("pend_hold_addr", imemaddr, 32'h10);
      chk("pend_hold_ren",  32'(imemREN), 32'h1);
    end
    ihit = 1'b1; imemload = 32'hDEAD_BEEF;
    tick;
    chk("pend_done_addr",  imemaddr, 32'h200);
    chk("pend_done_valid", 32'(IF_valid_OUT), 32'h0);
    chk("pend_done_instr", IF_Instr_OUT, 32'h0);
    imemload = I200;
    tick;
    chk("tgt_instr", IF_Instr_OUT, I200);
    chk("tgt_npc",   IF_npc_OUT, 32'h204);
    chk("tgt_valid", 32'(IF_valid_OUT), 32'h1);

    // PC wrap at top of address space
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick;
    redirect = 1'b0;
    chk("wrap_addr_top", imemaddr, 32'hFFFF_FFFC);
    imemload = I8;
    tick;
    chk("wrap_npc",   IF_npc_OUT, 32'h0);
    chk("wrap_addr",  imemaddr, 32'h0);
    chk("wrap_valid", 32'(IF_valid_OUT), 32'h1);

    // Miss without redirect inserts a bubble
    ihit = 1'b0;
    tick;
    chk("bubble_valid", 32'(IF_valid_OUT), 32'h0);
    chk("bubble_addr",  imemaddr, 32'h0);

    // advance low holds everything and ignores redirect
    ihit = 1'b1; imemload = I0;
    tick;
    chk("pre_hold_npc", IF_npc_OUT, 32'h4);
    advance = 1'b0; redirect = 1'b1; redirect_pc = 32'h400;
    #1 chk("noadv_flush", 32'(flush), 32'h0);
    tick;
    chk("noadv_addr",  imemaddr, 32'h4);
    chk("noadv_npc",   IF_npc_OUT, 32'h4);
    chk("noadv_valid", 32'(IF_valid_OUT), 32'h1);
    redirect = 1'b0; advance = 1'b1;

    // Halt during a miss
    ihit = 1'b0; halt = 1'b1;
    tick;
    chk("halt_ren",   32'(imemREN), 32'h0);
    chk("halt_valid", 32'(IF_valid_OUT), 32'h0);
    chk("halt_instr", IF_Instr_OUT, 32'h0);
    chk("halt_npc",   IF_npc_OUT, 32'h0);
    chk("halt_addr",  imemaddr, 32'h4);
    halt = 1'b0; ihit = 1'b1; redirect = 1'b1; redirect_pc = 32'h500;
    #1 chk("halt_flush", 32'(flush), 32'h0);
    repeat (2) tick;
    chk("halt_stay_ren",   32'(imemREN), 32'h0);
    chk("halt_stay_addr",  imemaddr, 32'h4);
    chk("halt_stay_valid", 32'(IF_valid_OUT), 32'h0);
    redirect = 1'b0;

    // Reset leaves HALTED
    RST = 1'b1;
    tick;
    RST = 1'b0;
    chk("unhalt_addr", imemaddr, 32'h0);
    chk("unhalt_ren",  32'(imemREN), 32'h1);
    imemload = I0;
    tick;
    chk("unhalt_fetch_addr", imemaddr, 32'h4);

    // Reset while PEND discards the pending target
    ihit = 1'b0; redirect = 1'b1; redirect_pc = 32'h300;
    tick;
    redirect = 1'b0;
    chk("pend2_addr", imemaddr, 32'h4);
    RST = 1'b1; ihit = 1'b1;
    tick;
    RST = 1'b0;
    chk("rst_pend_addr",  imemaddr, 32'h0);
    chk("rst_pend_valid", 32'(IF_valid_OUT), 32'h0);
    imemload = I0;
    tick;
    chk("rst_pend_fetch_addr",  imemaddr, 32'h4);
    chk("rst_pend_fetch_npc",   IF_npc_OUT, 32'h4);
    chk("rst_pend_fetch_instr", IF_Instr_OUT, I0);
    imemload = I4;
    tick;
    chk("rst_pend_next_addr", imemaddr, 32'h8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
